// File: rtl/full_adder_4a_if.sv
// Operand/result bundle for the registered ripple-carry adder.
// Master drives operands and samples results; slave is the adder.
interface full_adder_4a_if #(
  parameter int WIDTH = 4
);
  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ci;
  logic [WIDTH-1:0] so;
  logic             co;
  logic             ovf;
  logic             out_valid;

  modport master (
    output in_valid, a, b, ci,
    input  so, co, ovf, out_valid
  );

  modport slave (
    input  in_valid, a, b, ci,
    output so, co, ovf, out_valid
  );
endinterface

// File: rtl/full_adder_4a.sv
// Registered WIDTH-bit ripple-carry adder built from single-bit full-adder cells.
// One-cycle latency, one result per cycle, synchronous active-high reset.
module full_adder_4a_cell (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);
  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
endmodule

module full_adder_4a #(
  parameter int WIDTH = 4
) (
  input  logic           clk,
  input  logic           rst,
  full_adder_4a_if.slave bus
);
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum;
  logic             co_next;
  logic             ovf_next;

  logic [WIDTH-1:0] so_d, so_q;
  logic             co_d, co_q;
  logic             ovf_d, ovf_q;
  logic             out_valid_d, out_valid_q;

  assign carry[0] = bus.ci;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    full_adder_4a_cell u_cell (
      .a_i (bus.a[i]),
      .b_i (bus.b[i]),
      .c_i (carry[i]),
      .s_o (sum[i]),
      .c_o (carry[i+1])
    );
  end

  assign co_next  = carry[WIDTH];
  // Signed overflow: carry into the MSB disagrees with carry out of it.
  assign ovf_next = carry[WIDTH] ^ carry[WIDTH-1];

  always_comb begin
    so_d        = so_q;
    co_d        = co_q;
    ovf_d       = ovf_q;
    out_valid_d = bus.in_valid;
    if (bus.in_valid) begin
      so_d  = sum;
      co_d  = co_next;
      ovf_d = ovf_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      so_q        <= '0;
      co_q        <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      so_q        <= so_d;
      co_q        <= co_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.so        = so_q;
  assign bus.co        = co_q;
  assign bus.ovf       = ovf_q;
  assign bus.out_valid = out_valid_q;
endmodule

// File: tb/tb_full_adder_4a.sv
// Self-checking bench for full_adder_4a: directed table, corner sequences,
// exhaustive sweep and randomized traffic against an arithmetic reference model.
module tb_full_adder_4a;
  logic clk;
  logic rst;
  int   pass_cnt;
  int   total_cnt;

  full_adder_4a_if #(.WIDTH(4)) fa_if ();

  full_adder_4a #(.WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (fa_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       ci;
    logic [3:0] so;
    logic       co;
    logic       ovf;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got !== exp)
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    else
      pass_cnt++;
  endtask

  // Reference: plain integer arithmetic, signed view for overflow.
  task automatic model(input int a, input int b, input int ci,
                       output logic [3:0] s, output logic c, output logic o);
    int usum, sa, sb, ssum;
    usum = a + b + ci;
    s    = 4'(usum % 16);
    c    = (usum >= 16);
    sa   = (a >= 8) ? a - 16 : a;
    sb   = (b >= 8) ? b - 16 : b;
    ssum = sa + sb + ci;
    o    = (ssum > 7) || (ssum < -8);
  endtask

  task automatic drive(input logic v, input logic [3:0] a, input logic [3:0] b, input logic ci);
    fa_if.in_valid = v;
    fa_if.a        = a;
    fa_if.b        = b;
    fa_if.ci       = ci;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string name, input logic [3:0] so, input logic co,
                         input logic ovf, input logic ov);
    chk({name, ".so"},        32'(fa_if.so),        32'(so));
    chk({name, ".co"},        32'(fa_if.co),        32'(co));
    chk({name, ".ovf"},       32'(fa_if.ovf),       32'(ovf));
    chk({name, ".out_valid"}, 32'(fa_if.out_valid), 32'(ov));
  endtask

  initial begin
    logic [3:0] m_so;
    logic       m_co, m_ovf;
    logic [3:0] ra, rb;
    logic       rci, rv;

    pass_cnt  = 0;
    total_cnt = 0;
    vecs[0] = '{4'b0001, 4'b0001, 1'b0, 4'b0010, 1'b0, 1'b0};
    vecs[1] = '{4'b0011, 4'b0001, 1'b1, 4'b0101, 1'b0, 1'b0};
    vecs[2] = '{4'b0111, 4'b0111, 1'b1, 4'b1111, 1'b0, 1'b1};
    vecs[3] = '{4'b1001, 4'b0001, 1'b0, 4'b1010, 1'b0, 1'b0};
    vecs[4] = '{4'b1101, 4'b0010, 1'b1, 4'b0000, 1'b1, 1'b0};
    vecs[5] = '{4'b1001, 4'b0110, 1'b1, 4'b0000, 1'b1, 1'b0};
    vecs[6] = '{4'b1111, 4'b1111, 1'b1, 4'b1111, 1'b1, 1'b0};
    vecs[7] = '{4'b1000, 4'b1000, 1'b0, 4'b0000, 1'b1, 1'b1};
    vecs[8] = '{4'b0100, 4'b0100, 1'b0, 4'b1000, 1'b0, 1'b1};

    // Reset held two edges with a live, all-ones operand set.
    rst = 1'b1;
    drive(1'b1, 4'b1111, 4'b1111, 1'b1);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk_out("reset", 4'h0, 1'b0, 1'b0, 1'b0);
    end
    rst = 1'b0;

    foreach (vecs[i]) begin
      drive(1'b1, vecs[i].a, vecs[i].b, vecs[i].ci);
      tick();
      chk_out($sformatf("vec%0d", i), vecs[i].so, vecs[i].co, vecs[i].ovf, 1'b1);
    end

    // Hold: capture once, then idle with changing operands.
    drive(1'b1, 4'b0011, 4'b0100, 1'b0);
    tick();
    chk_out("hold_cap", 4'b0111, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 4'(i + 9), 4'(i + 5), 1'b1);
      tick();
      chk_out("hold_idle", 4'b0111, 1'b0, 1'b0, 1'b0);
    end

    // Reset beats a simultaneous valid capture.
    drive(1'b1, 4'b0111, 4'b0111, 1'b1);
    tick();
    rst = 1'b1;
    tick();
    chk_out("rst_prio", 4'h0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    drive(1'b0, 4'b0010, 4'b0011, 1'b0);
    tick();
    chk_out("post_rst_idle", 4'h0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 4'b0010, 4'b0011, 1'b0);
    tick();
    chk_out("post_rst_cap", 4'b0101, 1'b0, 1'b0, 1'b1);

    // Exhaustive back-to-back sweep.
    for (int ci = 0; ci < 2; ci++)
      for (int a = 0; a < 16; a++)
        for (int b = 0; b < 16; b++) begin
          drive(1'b1, 4'(a), 4'(b), 1'(ci));
          tick();
          model(a, b, ci, m_so, m_co, m_ovf);
          chk_out("exh", m_so, m_co, m_ovf, 1'b1);
        end

    // Randomized traffic; model remembers last captured result for idle cycles.
    model(15, 15, 1, m_so, m_co, m_ovf);
    for (int i = 0; i < 300; i++) begin
      ra  = 4'($urandom_range(0, 15));
      rb  = 4'($urandom_range(0, 15));
      rci = 1'($urandom_range(0, 1));
      rv  = ($urandom_range(0, 3) != 0);
      drive(rv, ra, rb, rci);
      tick();
      if (rv) model(int'(ra), int'(rb), int'(rci), m_so, m_co, m_ovf);
      chk_out("rand", m_so, m_co, m_ovf, rv);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
